// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and codes for the execute-stage hazard controller and the
// datapath operand muxes that consume its forwarding selects.
package ex_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MDU  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// execute-stage hazard controller (slave).
interface ex_hazard_ctrl_if;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic       MemtoRegE;
  logic [4:0] WriteRegM, WriteRegW;
  logic       RegWriteM, RegWriteW;
  logic       mdu_start_e;
  logic       halt_req, step_req, resume_req;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, StallW;
  logic       FlushE, FlushM;
  logic       halted, mdu_busy, mdu_done;

  modport master (
    output RsD, RtD, RsE, RtE, MemtoRegE, WriteRegM, WriteRegW,
           RegWriteM, RegWriteW, mdu_start_e, halt_req, step_req, resume_req,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
           FlushE, FlushM, halted, mdu_busy, mdu_done
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, MemtoRegE, WriteRegM, WriteRegW,
           RegWriteM, RegWriteW, mdu_start_e, halt_req, step_req, resume_req,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
           FlushE, FlushM, halted, mdu_busy, mdu_done
  );
endinterface

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
// Forwarding select for one execute-stage ALU operand; the MEM-stage
// result is younger than WB, so it wins when both match.
module fwd_unit
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] wr_m,
  input  logic       we_m,
  input  logic [4:0] wr_w,
  input  logic       we_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (we_m && (wr_m != 5'd0) && (wr_m == src))
      fwd = FWD_MEM;
    else if (we_w && (wr_w != 5'd0) && (wr_w == src))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall,
// multi-cycle mult/div sequencing and debugger halt/step/resume.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_hazard_ctrl_if.slave hz
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halt_pend_q, halt_pend_d;
  logic              lwstall;

  fwd_unit u_fwd_a (
    .src (hz.RsE), .wr_m(hz.WriteRegM), .we_m(hz.RegWriteM),
    .wr_w(hz.WriteRegW), .we_w(hz.RegWriteW), .fwd(hz.ForwardAE)
  );

  fwd_unit u_fwd_b (
    .src (hz.RtE), .wr_m(hz.WriteRegM), .we_m(hz.RegWriteM),
    .wr_w(hz.WriteRegW), .we_w(hz.RegWriteW), .fwd(hz.ForwardBE)
  );

  assign lwstall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
    hz.StallF   = 1'b0;
    hz.StallD   = 1'b0;
    hz.StallE   = 1'b0;
    hz.StallM   = 1'b0;
    hz.StallW   = 1'b0;
    hz.FlushE   = 1'b0;
    hz.FlushM   = 1'b0;
    hz.halted   = 1'b0;
    hz.mdu_busy = 1'b0;
    hz.mdu_done = 1'b0;

    case (state_q)
      ST_RUN: begin
        hz.StallF = lwstall;
        hz.StallD = lwstall;
        hz.FlushE = lwstall;
        if (hz.mdu_start_e) begin
          state_d     = ST_MDU;
          cnt_d       = CNT_W'(MDU_LAT - 1);
          halt_pend_d = hz.halt_req;
        end else if (hz.halt_req) begin
          state_d = ST_HALT;
        end
      end

      // Older instructions in M/W keep draining while the mult/div holds E.
      ST_MDU: begin
        hz.StallF   = 1'b1;
        hz.StallD   = 1'b1;
        hz.StallE   = 1'b1;
        hz.FlushM   = 1'b1;
        hz.mdu_busy = 1'b1;
        cnt_d       = cnt_q - CNT_W'(1);
        if (hz.halt_req) halt_pend_d = 1'b1;
        if (cnt_q == '0) begin
          hz.mdu_done = 1'b1;
          cnt_d       = '0;
          state_d     = (halt_pend_q || hz.halt_req) ? ST_HALT : ST_RUN;
          halt_pend_d = 1'b0;
        end
      end

      ST_HALT: begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.StallW = 1'b1;
        hz.halted = 1'b1;
        if (hz.resume_req)    state_d = ST_RUN;
        else if (hz.step_req) state_d = ST_STEP;
      end

      // One advancing clock; a stepped mult/div must finish before re-halting.
      ST_STEP: begin
        hz.StallF = lwstall;
        hz.StallD = lwstall;
        hz.FlushE = lwstall;
        if (hz.mdu_start_e) begin
          state_d     = ST_MDU;
          cnt_d       = CNT_W'(MDU_LAT - 1);
          halt_pend_d = 1'b1;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios then random traffic, all
// outputs compared each cycle against a behavioural model of the controller.
module tb_ex_hazard_ctrl;
  import ex_hazard_ctrl_pkg::*;

  localparam int MDU_LAT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_hazard_ctrl_if hz ();

  ex_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  int total = 0;
  int bad   = 0;

  // Model: remaining MDU cycles, halted flag, one-shot step flag, pending halt.
  int mdu_left;
  bit m_halt, m_step, m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] src, input logic [4:0] wm,
                                         input logic em, input logic [4:0] ww, input logic ew);
    if (em && wm != 0 && wm == src) return 2'b10;
    if (ew && ww != 0 && ww == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    mdu_left = 0; m_halt = 0; m_step = 0; m_pend = 0;
  endtask

  task automatic check_outputs();
    logic       lw;
    logic [4:0] st;
    logic [1:0] fl;
    logic [2:0] sts;
    lw = hz.MemtoRegE && (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
    if (mdu_left > 0) begin
      st = 5'b11100; fl = 2'b01; sts = {1'b0, 1'b1, mdu_left == 1};
    end else if (m_halt) begin
      st = 5'b11111; fl = 2'b00; sts = 3'b100;
    end else begin
      st = {lw, lw, 3'b000}; fl = {lw, 1'b0}; sts = 3'b000;
    end
    chk("fwdA", hz.ForwardAE, fwd_ref(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW));
    chk("fwdB", hz.ForwardBE, fwd_ref(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW));
    chk("stalls", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}, st);
    chk("flushes", {hz.FlushE, hz.FlushM}, fl);
    chk("status", {hz.halted, hz.mdu_busy, hz.mdu_done}, sts);
  endtask

  task automatic model_advance();
    if (mdu_left > 0) begin
      if (hz.halt_req) m_pend = 1;
      mdu_left--;
      if (mdu_left == 0) begin
        m_halt = m_pend;
        m_pend = 0;
      end
    end else if (m_halt) begin
      if (hz.resume_req) m_halt = 0;
      else if (hz.step_req) begin
        m_halt = 0;
        m_step = 1;
      end
    end else if (hz.mdu_start_e) begin
      mdu_left = MDU_LAT;
      m_pend   = m_step || hz.halt_req;
      m_step   = 0;
    end else if (m_step) begin
      m_step = 0;
      m_halt = 1;
    end else if (hz.halt_req) begin
      m_halt = 1;
    end
  endtask

  // Inputs are set just after posedge; outputs checked at negedge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0; hz.MemtoRegE = 0;
    hz.WriteRegM = 0; hz.WriteRegW = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.mdu_start_e = 0; hz.halt_req = 0; hz.step_req = 0; hz.resume_req = 0;
  endtask

  task automatic pulse(input logic s, input logic h, input logic st, input logic r);
    hz.mdu_start_e = s; hz.halt_req = h; hz.step_req = st; hz.resume_req = r;
    tick();
    hz.mdu_start_e = 0; hz.halt_req = 0; hz.step_req = 0; hz.resume_req = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst_n = 1'b1;

    // Forwarding priority and register-zero exclusion
    hz.RegWriteM = 1; hz.WriteRegM = 5; hz.RsE = 5; hz.RegWriteW = 1; hz.WriteRegW = 5;
    #1 chk("fwd_mem_priority", hz.ForwardAE, FWD_MEM);
    tick();
    hz.WriteRegM = 0; hz.RsE = 0; hz.WriteRegW = 0;
    #1 chk("fwd_zero_reg", hz.ForwardAE, FWD_RF);
    tick();
    hz.RsE = 7; hz.WriteRegW = 7; hz.RtE = 7; hz.WriteRegM = 7;
    tick();
    clear_inputs();

    // Load-use stall for exactly the matching cycle
    hz.MemtoRegE = 1; hz.RtE = 3; hz.RsD = 3;
    #1 chk("lwstall_on", {hz.StallF, hz.StallD, hz.FlushE}, 3'b111);
    tick();
    hz.MemtoRegE = 0;
    #1 chk("lwstall_off", {hz.StallF, hz.StallD, hz.FlushE}, 3'b000);
    tick();
    clear_inputs();

    // Plain MDU sequence
    pulse(1, 0, 0, 0);
    repeat (MDU_LAT + 2) tick();

    // Halt during MDU, then step, then step+resume
    pulse(1, 0, 0, 0);
    repeat (2) tick();
    pulse(0, 1, 0, 0);
    repeat (MDU_LAT) tick();
    pulse(0, 0, 1, 0);
    repeat (2) tick();
    pulse(0, 0, 1, 1);
    repeat (2) tick();

    // Step into a mult/div: it completes and then halts
    pulse(0, 1, 0, 0);
    hz.mdu_start_e = 1;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    repeat (MDU_LAT + 1) tick();
    pulse(0, 0, 0, 1);

    // Asynchronous reset mid-MDU
    pulse(1, 0, 0, 0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {hz.halted, hz.mdu_busy, hz.mdu_done}, 3'b000);
    chk("rst_stallE", hz.StallE, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    hz.MemtoRegE = 1; hz.RtE = 9; hz.RtD = 9;
    tick();
    clear_inputs();
    tick();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      hz.RsD = 5'($urandom_range(0, 3));
      hz.RtD = 5'($urandom_range(0, 3));
      hz.RsE = 5'($urandom_range(0, 3));
      hz.RtE = 5'($urandom_range(0, 3));
      hz.WriteRegM = 5'($urandom_range(0, 3));
      hz.WriteRegW = 5'($urandom_range(0, 3));
      hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.MemtoRegE = 1'($urandom_range(0, 1));
      hz.mdu_start_e = ($urandom_range(0, 9) == 0);
      hz.halt_req    = ($urandom_range(0, 11) == 0);
      hz.step_req    = ($urandom_range(0, 3) == 0);
      hz.resume_req  = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
